// File: rtl/demod_segment_decider_pkg.sv
// rtl/demod_segment_decider_pkg.sv - shared constants and state encoding for the segment decider
package demod_segment_decider_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int SEG_COUNT_DEF = 10;
    localparam int WORD_BITS_DEF = 8;
    // Headroom so the sum of many full-scale segments cannot wrap before clamping
    localparam int GUARD_BITS    = 4;

    localparam logic [31:0] ONE       = 32'h0001_0000;
    localparam logic [31:0] MINUS_ONE = 32'hFFFF_0000;
    localparam logic [31:0] SAT_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

endpackage

// File: rtl/demod_segment_decider_bit_packer.sv
// rtl/demod_segment_decider_bit_packer.sv - packs decision bits LSB-first into words
module demod_segment_decider_bit_packer #(
    parameter int WORD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_strobe_i,
    input  logic                 dec_bit_i,
    output logic [WORD_BITS-1:0] word_out_o,
    output logic                 word_valid_o
);

    localparam int PCNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [PCNT_W-1:0] LAST_IDX = PCNT_W'(WORD_BITS - 1);

    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [PCNT_W-1:0]    pack_cnt_q, pack_cnt_d;
    logic                 word_valid_q, word_valid_d;

    always_comb begin
        shreg_d      = shreg_q;
        word_d       = word_q;
        pack_cnt_d   = pack_cnt_q;
        word_valid_d = 1'b0;
        if (dec_strobe_i) begin
            shreg_d[pack_cnt_q] = dec_bit_i;
            if (pack_cnt_q == LAST_IDX) begin
                word_d       = shreg_d;
                word_valid_d = 1'b1;
                pack_cnt_d   = '0;
                shreg_d      = '0;
            end else begin
                pack_cnt_d = pack_cnt_q + PCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q      <= '0;
            word_q       <= '0;
            pack_cnt_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            pack_cnt_q   <= pack_cnt_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_out_o   = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/demod_segment_decider.sv
// rtl/demod_segment_decider.sv - sums per-segment correlations, decides one bit per frame, packs words
module demod_segment_decider
    import demod_segment_decider_pkg::*;
#(
    parameter int SEG_COUNT = SEG_COUNT_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_W-1:0]    seg_in,
    input  logic                 seg_valid,
    output logic                 busy,
    output logic                 valid,
    output logic                 bit_out,
    output logic [DATA_W-1:0]    metric,
    output logic                 tie,
    output logic                 sat,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_valid
);

    localparam int ACC_W = DATA_W + GUARD_BITS;
    localparam int CNT_W = $clog2(SEG_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(SEG_COUNT - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(GUARD_BITS + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(GUARD_BITS + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic                     bit_q, bit_d;
    logic [DATA_W-1:0]        metric_q, metric_d;
    logic                     tie_q, tie_d;
    logic                     sat_q, sat_d;
    logic                     dec_strobe;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        bit_d      = bit_q;
        metric_d   = metric_q;
        tie_d      = tie_q;
        sat_d      = sat_q;
        dec_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (seg_valid) begin
                    acc_d = acc_q + {{GUARD_BITS{seg_in[DATA_W-1]}}, seg_in};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SEG) begin
                        state_d = DECIDE;
                    end
                end
            end
            DECIDE: begin
                dec_strobe = 1'b1;
                valid_d    = 1'b1;
                bit_d      = (acc_q > 0);
                tie_d      = (acc_q == 0);
                if (acc_q > ACC_MAX) begin
                    metric_d = ACC_MAX[DATA_W-1:0];
                    sat_d    = 1'b1;
                end else if (acc_q < ACC_MIN) begin
                    metric_d = ACC_MIN[DATA_W-1:0];
                    sat_d    = 1'b1;
                end else begin
                    metric_d = acc_q[DATA_W-1:0];
                    sat_d    = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            bit_q    <= 1'b0;
            metric_q <= '0;
            tie_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            metric_q <= metric_d;
            tie_q    <= tie_d;
            sat_q    <= sat_d;
        end
    end

    // Packer registers the strobe too, so word_valid lands in the same cycle as valid
    demod_segment_decider_bit_packer #(
        .WORD_BITS (WORD_BITS)
    ) u_bit_packer (
        .clk          (clk),
        .reset        (reset),
        .dec_strobe_i (dec_strobe),
        .dec_bit_i    (bit_d),
        .word_out_o   (word_out),
        .word_valid_o (word_valid)
    );

    assign busy    = (state_q != IDLE);
    assign valid   = valid_q;
    assign bit_out = bit_q;
    assign metric  = metric_q;
    assign tie     = tie_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_demod_segment_decider.sv
// tb/tb_demod_segment_decider.sv - randomized self-checking bench for demod_segment_decider
module tb_demod_segment_decider;
    import demod_segment_decider_pkg::*;

    localparam int SEG = 10;
    localparam int WB  = 8;

    logic        clk = 1'b0;
    logic        reset, start, seg_valid;
    logic [31:0] seg_in;
    logic        busy, valid, bit_out, tie, sat, word_valid;
    logic [31:0] metric;
    logic [7:0]  word_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    logic [31:0] segs [SEG];
    bit          pend_bits [$];

    demod_segment_decider dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .busy       (busy),
        .valid      (valid),
        .bit_out    (bit_out),
        .metric     (metric),
        .tie        (tie),
        .sat        (sat),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from IDLE; returns in the valid cycle (still IDLE) so frames can chain.
    task automatic do_frame(input int gap_max, input bit noise);
        longint      s;
        logic [31:0] exp_metric;
        bit          exp_bit, exp_tie, exp_sat, exp_wv;
        logic [7:0]  exp_word;
        int          ng;
        s = 0;
        for (int i = 0; i < SEG; i++) s += longint'($signed(segs[i]));
        exp_sat = 1'b0;
        if (s > 64'sd2147483647) begin
            exp_metric = 32'h7FFF_FFFF; exp_sat = 1'b1;
        end else if (s < -64'sd2147483648) begin
            exp_metric = 32'h8000_0000; exp_sat = 1'b1;
        end else begin
            exp_metric = s[31:0];
        end
        exp_bit = (s > 0);
        exp_tie = (s == 0);
        pend_bits.push_back(exp_bit);
        exp_wv   = 1'b0;
        exp_word = '0;
        if (pend_bits.size() == WB) begin
            exp_wv = 1'b1;
            for (int i = 0; i < WB; i++) exp_word[i] = pend_bits[i];
            pend_bits.delete();
        end

        start = 1'b1; seg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0; seg_in = $urandom;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
        for (int i = 0; i < SEG; i++) begin
            ng = int'($urandom_range(0, gap_max));
            for (int g = 0; g < ng; g++) begin
                seg_valid = 1'b0; seg_in = $urandom;
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                tick;
            end
            seg_valid = 1'b1; seg_in = segs[i];
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0 at seg %0d", valid, i); end
        end
        checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL decide_cycle: got busy=%b valid=%b expected busy=1 valid=0", busy, valid); end
        seg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0; seg_in = $urandom;
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick;
        start = 1'b0; seg_valid = 1'b0;
        checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL valid_cycle: got valid=%b busy=%b expected valid=1 busy=0", valid, busy); end
        checks++; if (bit_out !== exp_bit) begin errors++; $display("FAIL bit_out: got %b expected %b", bit_out, exp_bit); end
        checks++; if (metric !== exp_metric) begin errors++; $display("FAIL metric: got %h expected %h", metric, exp_metric); end
        checks++; if (tie !== exp_tie) begin errors++; $display("FAIL tie: got %b expected %b", tie, exp_tie); end
        checks++; if (sat !== exp_sat) begin errors++; $display("FAIL sat: got %b expected %b", sat, exp_sat); end
        checks++; if (word_valid !== exp_wv) begin errors++; $display("FAIL word_valid: got %b expected %b", word_valid, exp_wv); end
        if (exp_wv) begin
            checks++; if (word_out !== exp_word) begin errors++; $display("FAIL word_out: got %h expected %h", word_out, exp_word); end
        end
        last_valid_cyc = cyc;
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < SEG; i++) segs[i] = v;
    endtask

    task automatic fill_random;
        int mode;
        for (int i = 0; i < SEG; i++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      segs[i] = $urandom;
            else if (mode == 1) segs[i] = 32'($signed(int'($urandom_range(0, 32'h0004_0000))) - 32'sh0002_0000);
            else                segs[i] = $urandom_range(0, 1) ? SAT_MAX : SAT_MIN;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; seg_valid = 1'b1; seg_in = $urandom;
        tick; tick;
        reset = 1'b0; start = 1'b0; seg_valid = 1'b0;
        pend_bits.delete();
        checks++; if ({busy, valid, bit_out, tie, sat, word_valid} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {busy, valid, bit_out, tie, sat, word_valid}); end
        checks++; if (metric !== 32'h0) begin errors++; $display("FAIL reset_metric: got %h expected 0", metric); end
        checks++; if (word_out !== 8'h0) begin errors++; $display("FAIL reset_word: got %h expected 0", word_out); end
        tick;
    endtask

    task automatic test_back_to_back;
        bit pattern [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        int prev;
        logic [31:0] mag;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < SEG; i++) begin
                mag = $urandom_range(1, 32'h0010_0000);
                segs[i] = pattern[f] ? mag : -mag;
            end
            prev = last_valid_cyc;
            do_frame(0, 1'b1);
            if (f > 0) begin
                checks++; if (last_valid_cyc - prev !== 12) begin errors++; $display("FAIL b2b_period: got %0d expected 12", last_valid_cyc - prev); end
            end
        end
        checks++; if (word_valid !== 1'b1 || word_out !== 8'h4D) begin errors++; $display("FAIL b2b_word: got wv=%b word=%h expected wv=1 word=4d", word_valid, word_out); end
        tick;
    endtask

    task automatic test_plus_one;
        fill_const(ONE);
        do_frame(0, 1'b0);
        checks++; if (metric !== 32'h000A_0000 || bit_out !== 1'b1) begin errors++; $display("FAIL plus_one: got metric=%h bit=%b expected 000a0000 1", metric, bit_out); end
        tick;
    endtask

    task automatic test_minus_one;
        fill_const(MINUS_ONE);
        do_frame(1, 1'b0);
        checks++; if (metric !== 32'hFFF6_0000 || bit_out !== 1'b0) begin errors++; $display("FAIL minus_one: got metric=%h bit=%b expected fff60000 0", metric, bit_out); end
        tick;
    endtask

    task automatic test_tie_gaps;
        logic [31:0] t;
        int j;
        for (int i = 0; i < SEG; i++) segs[i] = (i < SEG / 2) ? ONE : MINUS_ONE;
        for (int i = SEG - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = segs[i]; segs[i] = segs[j]; segs[j] = t;
        end
        do_frame(3, 1'b1);
        checks++; if (tie !== 1'b1 || metric !== 32'h0 || bit_out !== 1'b0) begin errors++; $display("FAIL tie_gaps: got tie=%b metric=%h bit=%b expected 1 0 0", tie, metric, bit_out); end
        tick;
    endtask

    task automatic test_saturation;
        fill_const(SAT_MAX);
        do_frame(0, 1'b0);
        checks++; if (metric !== 32'h7FFF_FFFF || sat !== 1'b1) begin errors++; $display("FAIL sat_pos: got metric=%h sat=%b expected 7fffffff 1", metric, sat); end
        fill_const(SAT_MIN);
        do_frame(0, 1'b0);
        checks++; if (metric !== 32'h8000_0000 || sat !== 1'b1) begin errors++; $display("FAIL sat_neg: got metric=%h sat=%b expected 80000000 1", metric, sat); end
        tick;
    endtask

    task automatic test_reset_abort;
        for (int f = 0; f < 3; f++) begin
            fill_random;
            do_frame(1, 1'b1);
        end
        tick;
        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seg_valid = 1'b1; seg_in = ONE; tick;
        end
        reset = 1'b1; start = 1'b1; seg_valid = 1'b1;
        tick;
        reset = 1'b0; start = 1'b0; seg_valid = 1'b0;
        pend_bits.delete();
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL abort_busy: got busy=%b valid=%b expected 0 0", busy, valid); end
        checks++; if (metric !== 32'h0 || bit_out !== 1'b0) begin errors++; $display("FAIL abort_outputs: got metric=%h bit=%b expected 0 0", metric, bit_out); end
        for (int i = 0; i < 12; i++) begin
            seg_valid = 1'b1; seg_in = ONE; tick;
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet: got valid=%b busy=%b expected 0 0", valid, busy); end
        end
        seg_valid = 1'b0;
        fill_const(ONE);
        do_frame(0, 1'b0);
        checks++; if (metric !== 32'h000A_0000) begin errors++; $display("FAIL abort_next: got %h expected 000a0000", metric); end
        for (int f = 0; f < 7; f++) begin
            fill_random;
            do_frame(1, 1'b1);
        end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL abort_word_restart: got %b expected 1", word_valid); end
        tick;
    endtask

    task automatic test_random;
        for (int f = 0; f < 20; f++) begin
            fill_random;
            do_frame(2, 1'b1);
            if ($urandom_range(0, 1)) tick;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seg_valid = 1'b0; seg_in = '0;
        test_reset;
        test_back_to_back;
        test_plus_one;
        test_minus_one;
        test_tie_gaps;
        test_saturation;
        test_reset_abort;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
